cpu_exec_unit: RTL and testbench
================================

// Module: cpu_exec_unit
// PURPOSE
// - 16-bit execution unit (datapath) driven by the control-unit FSM's control word; sits between the control unit and the memory.
// - Holds the 8x16 register file, the ALU, the PC and the IR; produces the memory address and write data.
// - Returns IR and the raw ALU status flags N/Z/C. The control unit registers the flags; this block does not.
// PARAMETERS
// - DATA_W    16       datapath width; the design and the tests are fixed at 16
// - RF_ADR_W  3        register-file address width, giving 8 registers
// - RESET_PC  16'h0000 PC value on reset
// PORTS
// - clk      in   1   clock; all state updates on posedge
// - reset    in   1   asynchronous, active-high reset
// - W_Adr    in   3   register-file write address
// - R_Adr    in   3   register-file read port R address
// - S_Adr    in   3   register-file read port S address
// - adr_sel  in   1   Address mux: 0 = PC, 1 = R
// - s_sel    in   1   register write-data mux: 0 = ALU result, 1 = D_in
// - pc_ld    in   1   load PC (target chosen by pc_sel)
// - pc_inc   in   1   PC <- PC+1
// - pc_sel   in   1   PC load source: 0 = PC + sext(IR[7:0]), 1 = S
// - ir_ld    in   1   IR <- D_in
// - rw_en    in   1   register-file write enable
// - alu_op   in   4   ALU operation code
// - D_in     in   16  memory read data; combinational, valid in the same cycle as Address
// - Address  out  16  memory address
// - D_out    out  16  memory write data (= S)
// - IR       out  16  instruction register
// - N        out  1   ALU result bit 15 (combinational)
// - Z        out  1   ALU result == 0 (combinational)
// - C        out  1   ALU carry/borrow/shift-out (combinational)
// BEHAVIOUR
// - Reset (async): PC=RESET_PC, IR=0, all 8 registers=0. Outputs follow combinationally from that state.
// - Register-file reads R=RF[R_Adr] and S=RF[S_Adr] are combinational and read-before-write.
//   - A write to the same address becomes visible in the cycle after the edge.
// - Register write: on posedge, if rw_en, RF[W_Adr] <- (s_sel ? D_in : alu_out). All 8 registers are writable, including R0.
// - ALU: 17-bit internal result; alu_out = low 16 bits.
//   - 0000 S (C=0)
//   - 0001 R (C=0)
//   - 0010 S+1 (C=carry)
//   - 0011 S-1 (C=borrow)
//   - 0100 R+S (C=carry)
//   - 0101 R-S (C=borrow, i.e. R<S unsigned)
//   - 0110 S>>1 logical (C=S[0])
//   - 0111 S<<1 (C=S[15])
//   - 1000 R&S, 1001 R|S, 1010 R^S, 1011 ~S (all C=0)
//   - 1100 0-S (C=(S!=0))
//   - 1101-1111 result 0 (C=0)
// - Flags: N=alu_out[15], Z=(alu_out==16'h0000). Flags are evaluated every cycle regardless of rw_en.
// - PC priority on posedge: pc_ld > pc_inc > hold.
//   - pc_ld, pc_sel=0: PC <- PC + {{8{IR[7]}},IR[7:0]}, modulo 2^16.
//   - pc_ld, pc_sel=1: PC <- S.
//   - pc_inc: PC <- PC+1; FFFF wraps to 0000.
// - IR: on posedge, if ir_ld, IR <- D_in; otherwise hold.
//   - ir_ld and pc_inc together (fetch): IR captures M[old PC] and PC advances in the same edge.
// - Address = adr_sel ? R : PC. D_out = S always. The memory write strobe is owned by the control unit.
// - Load-immediate (s_sel=1, adr_sel=0, pc_inc=1, rw_en=1): RF[W_Adr] <- M[PC] and PC+1 in one edge.
// - Reset mid-operation: all state clears immediately. No partial register write occurs on an edge coincident with reset.
// - No internal FSM beyond these registers; latency = 1 clk for every state update.
// TESTING
// - Reset: assert reset while PC=1234 and R3=BEEF -> PC=0000, IR=0000, all registers read 0000, Address=0000.
// - Fetch: D_in=E0D1, ir_ld=1, pc_inc=1 at PC=0005 -> IR=E0D1, PC=0006.
// - ALU/flags, with R=8000, S=8000, op 0100 -> alu_out=0000, N=0, Z=1, C=1.
//   - Op 0101 with R=0001, S=0002 -> FFFF, N=1, Z=0, C=1.
//   - Op 0110 with S=0003 -> 0001, C=1.
// - Branch, with PC=0010, IR[7:0]=FC, pc_ld=1, pc_sel=0 -> PC=000C.
//   - pc_sel=1 with S=4000 -> PC=4000.
//   - pc_ld and pc_inc both set -> load wins.
// - Load/store: adr_sel=1 with R=0200 -> Address=0200, D_out=S.
//   - s_sel=1, rw_en=1, W_Adr=5, D_in=ABCD -> R5=ABCD next cycle; the same-cycle read of R5 still returns the old value.
// - Wrap: PC=FFFF with pc_inc -> 0000; PC=0001 with IR[7:0]=80 and a branch load -> PC=FF81.

Source files
------------

// File: rtl/cpu_exec_unit.sv
// 16-bit execution unit: register file, ALU, PC and IR driven by the control word.
// ALU flags are raw combinational outputs; the control unit registers them.
module cpu_exec_unit #(
    parameter int                  DATA_W   = 16,
    parameter int                  RF_ADR_W = 3,
    parameter logic [DATA_W-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RF_ADR_W-1:0] W_Adr,
    input  logic [RF_ADR_W-1:0] R_Adr,
    input  logic [RF_ADR_W-1:0] S_Adr,
    input  logic                adr_sel,
    input  logic                s_sel,
    input  logic                pc_ld,
    input  logic                pc_inc,
    input  logic                pc_sel,
    input  logic                ir_ld,
    input  logic                rw_en,
    input  logic [3:0]          alu_op,
    input  logic [DATA_W-1:0]   D_in,
    output logic [DATA_W-1:0]   Address,
    output logic [DATA_W-1:0]   D_out,
    output logic [DATA_W-1:0]   IR,
    output logic                N,
    output logic                Z,
    output logic                C
);

    localparam int unsigned     NREG  = 2 ** RF_ADR_W;
    localparam logic [DATA_W:0] ONE_X = (DATA_W + 1)'(1);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] s_val;
    logic [DATA_W:0]   alu_res;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] pc_branch;

    assign r_val = rf[R_Adr];
    assign s_val = rf[S_Adr];

    // Bit DATA_W of alu_res carries C for every op; subtractions yield borrow there.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'h0: alu_res = {1'b0, s_val};
            4'h1: alu_res = {1'b0, r_val};
            4'h2: alu_res = {1'b0, s_val} + ONE_X;
            4'h3: alu_res = {1'b0, s_val} - ONE_X;
            4'h4: alu_res = {1'b0, r_val} + {1'b0, s_val};
            4'h5: alu_res = {1'b0, r_val} - {1'b0, s_val};
            4'h6: alu_res = {s_val[0], 1'b0, s_val[DATA_W-1:1]};
            4'h7: alu_res = {s_val, 1'b0};
            4'h8: alu_res = {1'b0, r_val & s_val};
            4'h9: alu_res = {1'b0, r_val | s_val};
            4'hA: alu_res = {1'b0, r_val ^ s_val};
            4'hB: alu_res = {1'b0, ~s_val};
            4'hC: alu_res = {(DATA_W + 1){1'b0}} - {1'b0, s_val};
            default: alu_res = '0;
        endcase
    end

    assign alu_out = alu_res[DATA_W-1:0];
    assign N       = alu_out[DATA_W-1];
    assign Z       = (alu_out == '0);
    assign C       = alu_res[DATA_W];

    assign wr_data   = s_sel ? D_in : alu_out;
    assign pc_branch = pc + {{(DATA_W - 8){IR[7]}}, IR[7:0]};

    assign Address = adr_sel ? r_val : pc;
    assign D_out   = s_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (rw_en) begin
            rf[W_Adr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_ld) begin
            pc <= pc_sel ? s_val : pc_branch;
        end else if (pc_inc) begin
            pc <= pc + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IR <= '0;
        end else if (ir_ld) begin
            IR <= D_in;
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Bench for cpu_exec_unit: fixed vector table, hand-written corner sequences and
// random control words checked against an arithmetic reference model.
module tb_cpu_exec_unit;

    typedef struct packed {
        logic [2:0]  w;
        logic [2:0]  r;
        logic [2:0]  s;
        logic        adr_sel;
        logic        s_sel;
        logic        pc_ld;
        logic        pc_inc;
        logic        pc_sel;
        logic        ir_ld;
        logic        rw_en;
        logic [3:0]  op;
        logic [15:0] din;
    } ctrl_t;

    typedef struct {
        ctrl_t       c;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [15:0] ir;
        logic [2:0]  nzc;
    } row_t;

    logic        clk;
    logic        reset;
    ctrl_t       cc;
    logic [15:0] Address, D_out, IR;
    logic        N, Z, C;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_rf [8];

    cpu_exec_unit #(.DATA_W(16), .RF_ADR_W(3), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .W_Adr(cc.w), .R_Adr(cc.r), .S_Adr(cc.s),
        .adr_sel(cc.adr_sel), .s_sel(cc.s_sel), .pc_ld(cc.pc_ld), .pc_inc(cc.pc_inc),
        .pc_sel(cc.pc_sel), .ir_ld(cc.ir_ld), .rw_en(cc.rw_en), .alu_op(cc.op),
        .D_in(cc.din), .Address(Address), .D_out(D_out), .IR(IR),
        .N(N), .Z(Z), .C(C)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {carry, result} computed with plain unsigned arithmetic.
    function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
        int unsigned ri, si, v;
        logic c;
        ri = r; si = s; v = 0; c = 1'b0;
        case (op)
            4'd0:  v = si;
            4'd1:  v = ri;
            4'd2:  begin v = (si + 1) % 65536;         c = (si == 65535); end
            4'd3:  begin v = (si + 65535) % 65536;     c = (si == 0);     end
            4'd4:  begin v = (ri + si) % 65536;        c = (ri + si) > 65535; end
            4'd5:  begin v = (ri + 65536 - si) % 65536; c = (ri < si);    end
            4'd6:  begin v = si / 2;                   c = (si % 2) == 1; end
            4'd7:  begin v = (si * 2) % 65536;         c = (si >= 32768); end
            4'd8:  v = ri & si;
            4'd9:  v = ri | si;
            4'd10: v = ri ^ si;
            4'd11: v = 65535 - si;
            4'd12: begin v = (65536 - si) % 65536;     c = (si != 0);     end
            default: v = 0;
        endcase
        return {c, v[15:0]};
    endfunction

    task automatic model_clear();
        m_pc = 16'h0000;
        m_ir = 16'h0000;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    endtask

    task automatic model_commit();
        logic [16:0] a;
        logic [15:0] s_old, npc;
        int off;
        a     = ref_alu(cc.op, m_rf[cc.r], m_rf[cc.s]);
        s_old = m_rf[cc.s];
        off   = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
        npc   = m_pc;
        if (cc.pc_ld)       npc = cc.pc_sel ? s_old : 16'((int'(m_pc) + off + 65536) % 65536);
        else if (cc.pc_inc) npc = 16'((int'(m_pc) + 1) % 65536);
        if (cc.rw_en) m_rf[cc.w] = cc.s_sel ? cc.din : a[15:0];
        if (cc.ir_ld) m_ir = cc.din;
        m_pc = npc;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [16:0] a;
        a = ref_alu(cc.op, m_rf[cc.r], m_rf[cc.s]);
        chk({tag, " addr"}, Address, cc.adr_sel ? m_rf[cc.r] : m_pc);
        chk({tag, " dout"}, D_out, m_rf[cc.s]);
        chk({tag, " ir"}, IR, m_ir);
        chk({tag, " nzc"}, {13'd0, N, Z, C}, {13'd0, a[15], a[15:0] == 16'h0000, a[16]});
    endtask

    // Drive a control word and wait to the sampling point before the next edge.
    task automatic run(input ctrl_t c);
        cc = c;
        @(negedge clk);
    endtask

    task automatic edge_();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [15:0] val);
        ctrl_t c;
        c = '0; c.w = idx; c.s_sel = 1'b1; c.rw_en = 1'b1; c.din = val;
        run(c); edge_();
    endtask

    task automatic set_pc(input logic [15:0] val);
        ctrl_t c;
        wr_reg(3'd7, val);
        c = '0; c.s = 3'd7; c.pc_ld = 1'b1; c.pc_sel = 1'b1;
        run(c); edge_();
    endtask

    task automatic set_ir(input logic [15:0] val);
        ctrl_t c;
        c = '0; c.ir_ld = 1'b1; c.din = val;
        run(c); edge_();
    endtask

    task automatic peek_pc(input string nm, input logic [15:0] exp);
        ctrl_t c;
        c = '0;
        run(c);
        chk(nm, Address, exp);
        edge_();
    endtask

    row_t tbl [14];

    initial begin
        ctrl_t c;
        //            w  r  s  as ss ld in ps il rw op  din        addr      dout      ir        nzc
        tbl[0]  = '{'{3'd1,3'd0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h0,16'h8000}, 16'h0000,16'h0000,16'h0000,3'b010};
        tbl[1]  = '{'{3'd2,3'd1,3'd1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h4,16'h8000}, 16'h0000,16'h8000,16'h0000,3'b011};
        tbl[2]  = '{'{3'd3,3'd1,3'd2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h4,16'h0001}, 16'h8000,16'h8000,16'h0000,3'b011};
        tbl[3]  = '{'{3'd4,3'd3,3'd4,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,16'h0002}, 16'h0001,16'h0000,16'h0000,3'b000};
        tbl[4]  = '{'{3'd0,3'd3,3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h5,16'h0000}, 16'h0000,16'h0002,16'h0000,3'b101};
        tbl[5]  = '{'{3'd5,3'd0,3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'h6,16'h0003}, 16'h0000,16'h0001,16'h0000,3'b011};
        tbl[6]  = '{'{3'd6,3'd0,3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'h6,16'h0000}, 16'h0000,16'h0003,16'h0000,3'b001};
        tbl[7]  = '{'{3'd0,3'd6,3'd6,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,16'h0000}, 16'h0001,16'h0001,16'h0000,3'b000};
        tbl[8]  = '{'{3'd0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,4'hB,16'hE0D1}, 16'h0001,16'h0000,16'h0000,3'b100};
        tbl[9]  = '{'{3'd0,3'd0,3'd1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'h7,16'h0000}, 16'h0002,16'h8000,16'hE0D1,3'b011};
        tbl[10] = '{'{3'd0,3'd0,3'd3,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'hC,16'h0000}, 16'hFFD3,16'h0001,16'hE0D1,3'b101};
        tbl[11] = '{'{3'd0,3'd1,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h8,16'h0000}, 16'h0001,16'h8000,16'hE0D1,3'b100};
        tbl[12] = '{'{3'd0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'hD,16'h0000}, 16'h0001,16'h0000,16'hE0D1,3'b010};
        tbl[13] = '{'{3'd0,3'd1,3'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h9,16'h0000}, 16'h0001,16'h0001,16'hE0D1,3'b100};

        reset = 1'b1;
        cc    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        c = '0;
        run(c);
        chk("reset addr", Address, 16'h0000);
        chk("reset dout", D_out, 16'h0000);
        chk("reset ir", IR, 16'h0000);
        chk("reset nzc", {13'd0, N, Z, C}, 16'h0002);
        edge_();

        for (int i = 0; i < 14; i++) begin
            run(tbl[i].c);
            chk($sformatf("vec%0d addr", i), Address, tbl[i].addr);
            chk($sformatf("vec%0d dout", i), D_out, tbl[i].dout);
            chk($sformatf("vec%0d ir", i), IR, tbl[i].ir);
            chk($sformatf("vec%0d nzc", i), {13'd0, N, Z, C}, {13'd0, tbl[i].nzc});
            edge_();
        end

        // Fetch at PC=0005
        set_pc(16'h0005);
        c = '0; c.ir_ld = 1'b1; c.pc_inc = 1'b1; c.din = 16'hE0D1;
        run(c); edge_();
        chk("fetch ir", IR, 16'hE0D1);
        peek_pc("fetch pc", 16'h0006);

        // Backward branch
        set_pc(16'h0010);
        set_ir(16'h00FC);
        c = '0; c.pc_ld = 1'b1;
        run(c); edge_();
        peek_pc("branch back", 16'h000C);

        // Register target; load beats increment
        wr_reg(3'd2, 16'h4000);
        c = '0; c.pc_ld = 1'b1; c.pc_sel = 1'b1; c.pc_inc = 1'b1; c.s = 3'd2;
        run(c); edge_();
        peek_pc("jump reg", 16'h4000);

        // Wrap cases
        set_pc(16'hFFFF);
        c = '0; c.pc_inc = 1'b1;
        run(c); edge_();
        peek_pc("pc wrap", 16'h0000);
        set_pc(16'h0001);
        set_ir(16'h0080);
        c = '0; c.pc_ld = 1'b1;
        run(c); edge_();
        peek_pc("branch wrap", 16'hFF81);

        // Store addressing and same-cycle read of a register being written
        wr_reg(3'd1, 16'h0200);
        wr_reg(3'd4, 16'h1357);
        c = '0; c.adr_sel = 1'b1; c.r = 3'd1; c.s = 3'd4;
        run(c);
        chk("store addr", Address, 16'h0200);
        chk("store dout", D_out, 16'h1357);
        edge_();
        wr_reg(3'd5, 16'h1111);
        c = '0; c.w = 3'd5; c.r = 3'd5; c.adr_sel = 1'b1; c.s_sel = 1'b1; c.rw_en = 1'b1; c.din = 16'hABCD;
        run(c);
        chk("rbw old", Address, 16'h1111);
        edge_();
        chk("rbw new", Address, 16'hABCD);

        for (int i = 0; i < 400; i++) begin
            c = ctrl_t'({$urandom, $urandom});
            run(c);
            check_model($sformatf("rnd%0d", i));
            edge_();
        end

        // Reset mid-operation with a pending write on the coincident edge
        wr_reg(3'd3, 16'hBEEF);
        set_pc(16'h1234);
        peek_pc("pre-reset pc", 16'h1234);
        c = '0; c.w = 3'd3; c.s_sel = 1'b1; c.rw_en = 1'b1; c.din = 16'h5555;
        c.pc_inc = 1'b1; c.ir_ld = 1'b1;
        cc = c;
        #1 reset = 1'b1;
        #1;
        chk("rst pc", Address, 16'h0000);
        chk("rst ir", IR, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            c = '0; c.r = 3'(i); c.adr_sel = 1'b1;
            run(c);
            chk($sformatf("rst r%0d", i), Address, 16'h0000);
            edge_();
        end
        peek_pc("rst pc hold", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
